// File: rtl/mul_sched.sv
// Round-robin scheduler and bit-serial shift-add sequencer for a shared WIDTH x WIDTH multiplier.
// Optional MUL_EARLY_EXIT_EN: stop iterating once no multiplier bits remain set.
module mul_sched #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic [1:0]           ack,
  output logic                 busy,
  output logic                 done,
  output logic                 done_id,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic [PW-1:0]    prod_q, prod_d;

  logic             win_c;
  logic [PW-1:0]    acc_nxt_c;
  logic             last_iter_c;

  // Tie goes to the client not served last; a lone requester always wins.
  assign win_c     = (req[0] & req[1]) ? ~last_q : req[1];
  assign acc_nxt_c = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

`ifdef MUL_EARLY_EXIT_EN
  assign last_iter_c = (cnt_q == CNT_W'(WIDTH - 1)) || ((mplier_q >> 1) == '0);
`else
  assign last_iter_c = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ack_d     = 2'b00;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    prod_d    = prod_q;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          last_d   = win_c;
          id_d     = win_c;
          mcand_d  = {{WIDTH{1'b0}}, (win_c ? a1 : a0)};
          mplier_d = win_c ? b1 : b0;
          acc_d    = '0;
          cnt_d    = '0;
          ack_d    = win_c ? 2'b10 : 2'b01;
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d    = acc_nxt_c;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_iter_c) begin
          prod_d    = acc_nxt_c;
          done_d    = 1'b1;
          done_id_d = id_q;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ack_q     <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      prod_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      id_q      <= id_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      prod_q    <= prod_d;
    end
  end

  assign ack     = ack_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign prod    = prod_q;

endmodule

// File: tb/tb_mul_sched.sv
// Directed self-checking bench for mul_sched: vector table plus multi-cycle corner sequences.
module tb_mul_sched;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [7:0]  a0, b0, a1, b1;
  logic [1:0]  ack;
  logic        busy, done, done_id;
  logic [15:0] prod;

  int total = 0;
  int bad   = 0;
  logic [15:0] prev_prod = 16'd0;

  mul_sched #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack(ack), .busy(busy), .done(done), .done_id(done_id), .prod(prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [7:0]  a0, b0, a1, b1;
    logic [1:0]  exp_ack;
    logic [15:0] exp_prod;
  } vec_t;

  vec_t tbl [9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Expected iteration count (= cycles from ack to done) for multiplier b.
  function automatic int iters(input logic [7:0] b);
    int n;
`ifdef MUL_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < 8; i++) if (b[i]) n = i + 1;
`else
    n = 8;
`endif
    return n;
  endfunction

  task automatic run_vec(input vec_t v);
    int lat;
    logic [7:0] bw;
    req = v.req; a0 = v.a0; b0 = v.b0; a1 = v.a1; b1 = v.b1;
    bw = v.exp_ack[1] ? v.b1 : v.b0;
    step();
    chk("ack", 32'(ack), 32'(v.exp_ack));
    chk("busy_at_ack", 32'(busy), 32'd1);
    chk("prod_hold", 32'(prod), 32'(prev_prod));
    req = 2'b00;
    step();
    lat = 1;
    chk("ack_pulse", 32'(ack), 32'd0);
    while (!done && lat < 40) begin
      step();
      lat++;
    end
    chk("latency", 32'(lat), 32'(iters(bw)));
    chk("prod", 32'(prod), 32'(v.exp_prod));
    chk("done_id", 32'(done_id), 32'(v.exp_ack[1]));
    chk("busy_in_done", 32'(busy), 32'd1);
    prev_prod = v.exp_prod;
    step();
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_fall", 32'(busy), 32'd0);
  endtask

  int ack_t[$];
  logic [1:0] ack_v[$];
  logic [15:0] dn_p[$];
  logic dn_i[$];
  int low_gap[$];

  initial begin
    int lat, cyc, low;
    logic seen_ack;

    tbl[0] = '{2'b01, 8'd37,  8'd16,  8'd0,   8'd0,   2'b01, 16'd592};
    tbl[1] = '{2'b10, 8'd0,   8'd0,   8'd255, 8'd255, 2'b10, 16'd65025};
    tbl[2] = '{2'b01, 8'd0,   8'd77,  8'd0,   8'd0,   2'b01, 16'd0};
    tbl[3] = '{2'b01, 8'd200, 8'd0,   8'd0,   8'd0,   2'b01, 16'd0};
    tbl[4] = '{2'b11, 8'd3,   8'd4,   8'd5,   8'd6,   2'b10, 16'd30};
    tbl[5] = '{2'b11, 8'd3,   8'd4,   8'd5,   8'd6,   2'b01, 16'd12};
    tbl[6] = '{2'b10, 8'd0,   8'd0,   8'd128, 8'd128, 2'b10, 16'd16384};
    tbl[7] = '{2'b01, 8'd255, 8'd1,   8'd0,   8'd0,   2'b01, 16'd255};
    tbl[8] = '{2'b01, 8'd1,   8'd128, 8'd0,   8'd0,   2'b01, 16'd128};

    reset = 1'b0; req = 2'b00; a0 = 8'd0; b0 = 8'd0; a1 = 8'd0; b1 = 8'd0;
    #20;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    chk("rst_prod", 32'(prod), 32'd0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // Client 1 requests mid-RUN of client 0: waits until IDLE.
    req = 2'b01; a0 = 8'd37; b0 = 8'd16; a1 = 8'd5; b1 = 8'd6;
    step();
    chk("mid_ack0", 32'(ack), 32'd1);
    req = 2'b00;
    step(); step();
    req = 2'b10;
    seen_ack = 1'b0;
    lat = 2;
    while (!done && lat < 40) begin
      step();
      lat++;
      if (ack != 2'b00) seen_ack = 1'b1;
    end
    chk("mid_no_ack", 32'(seen_ack), 32'd0);
    chk("mid_lat0", 32'(lat), 32'(iters(8'd16)));
    chk("mid_prod0", 32'(prod), 32'd592);
    chk("mid_id0", 32'(done_id), 32'd0);
    step();
    chk("mid_ack_in_done", 32'(ack), 32'd0);
    step();
    chk("mid_ack1", 32'(ack), 32'd2);
    req = 2'b00;
    lat = 0;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
    chk("mid_lat1", 32'(lat), 32'(iters(8'd6)));
    chk("mid_prod1", 32'(prod), 32'd30);
    chk("mid_id1", 32'(done_id), 32'd1);
    step();

    // Both held for three jobs: last served was client 1, so grants 0,1,0.
    req = 2'b11; a0 = 8'd3; b0 = 8'd4; a1 = 8'd5; b1 = 8'd6;
    ack_t.delete(); ack_v.delete(); dn_p.delete(); dn_i.delete();
    cyc = 0;
    while (dn_p.size() < 3 && cyc < 80) begin
      step();
      cyc++;
      if (done) begin dn_p.push_back(prod); dn_i.push_back(done_id); end
      if (ack != 2'b00) begin
        ack_t.push_back(cyc); ack_v.push_back(ack);
        if (ack_t.size() == 3) req = 2'b00;
      end
    end
    chk("rr_acks", 32'(ack_t.size()), 32'd3);
    chk("rr_dones", 32'(dn_p.size()), 32'd3);
    if (ack_t.size() == 3 && dn_p.size() == 3) begin
      chk("rr_g0", 32'(ack_v[0]), 32'd1);
      chk("rr_g1", 32'(ack_v[1]), 32'd2);
      chk("rr_g2", 32'(ack_v[2]), 32'd1);
      chk("rr_p0", 32'(dn_p[0]), 32'd12);
      chk("rr_p1", 32'(dn_p[1]), 32'd30);
      chk("rr_p2", 32'(dn_p[2]), 32'd12);
      chk("rr_i0", 32'(dn_i[0]), 32'd0);
      chk("rr_i1", 32'(dn_i[1]), 32'd1);
      chk("rr_i2", 32'(dn_i[2]), 32'd0);
      chk("rr_gap0", 32'(ack_t[1] - ack_t[0]), 32'(iters(8'd4) + 2));
      chk("rr_gap1", 32'(ack_t[2] - ack_t[1]), 32'(iters(8'd6) + 2));
    end
    step();

    // Back-to-back single client, b0 = 1,2,3,4.
    req = 2'b01; a0 = 8'd10; b0 = 8'd1;
    ack_t.delete(); dn_p.delete(); low_gap.delete();
    cyc = 0; low = 0;
    while (dn_p.size() < 4 && cyc < 100) begin
      step();
      cyc++;
      if (done) dn_p.push_back(prod);
      if (ack != 2'b00) begin
        if (ack_t.size() > 0) low_gap.push_back(low);
        ack_t.push_back(cyc);
        low = 0;
        b0 = b0 + 8'd1;
        if (ack_t.size() == 4) req = 2'b00;
      end else if (!busy) begin
        low++;
      end
    end
    chk("b2b_acks", 32'(ack_t.size()), 32'd4);
    chk("b2b_dones", 32'(dn_p.size()), 32'd4);
    if (ack_t.size() == 4 && dn_p.size() == 4) begin
      for (int k = 1; k < 4; k++) begin
        chk("b2b_gap", 32'(ack_t[k] - ack_t[k-1]), 32'(iters(8'(k)) + 2));
        chk("b2b_busy_low", 32'(low_gap[k-1]), 32'd1);
      end
      for (int k = 0; k < 4; k++) chk("b2b_prod", 32'(dn_p[k]), 32'(10 * (k + 1)));
    end
    step();

    // Async reset three cycles into RUN; last must return to 1.
    req = 2'b01; a0 = 8'd37; b0 = 8'd16;
    step();
    chk("rr_pre_ack", 32'(ack), 32'd1);
    req = 2'b00;
    step(); step(); step();
    #2 reset = 1'b0;
    #1;
    chk("arst_ack", 32'(ack), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_id", 32'(done_id), 32'd0);
    chk("arst_prod", 32'(prod), 32'd0);
    step(); step();
    reset = 1'b1;
    req = 2'b11; a0 = 8'd3; b0 = 8'd4; a1 = 8'd5; b1 = 8'd6;
    step();
    chk("arst_first_grant", 32'(ack), 32'd1);
    req = 2'b00;
    lat = 0;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
    chk("arst_lat", 32'(lat), 32'(iters(8'd4)));
    chk("arst_prod_new", 32'(prod), 32'd12);
    chk("arst_id_new", 32'(done_id), 32'd0);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
